pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage RV32I pipeline (IF/ID/EX/MEM/WB).

---
 rtl/rv32i_types.sv | 22 ++
 rtl/sat_counter.sv | 31 +++
 rtl/pipeline_ctrl.sv | 128 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_types.sv
// Shared types for the RV32I pipeline sequencer: FSM states and the per-stage enable bundle.
package rv32i_types;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } pipe_state_t;

    typedef struct packed {
        logic pc;
        logic if_id;
        logic id_ex;
        logic ex_mem;
        logic mem_wb;
    } stage_en_t;

    localparam stage_en_t EN_NONE = '0;
    localparam stage_en_t EN_ALL  = '1;
    // Load-use bubble: hold PC and IF/ID, let ID/EX take a NOP, drain the back end.
    localparam stage_en_t EN_HAZ  = '{pc: 1'b0, if_id: 1'b0, id_ex: 1'b1, ex_mem: 1'b1, mem_wb: 1'b1};

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear; sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: merges cache handshakes, load-use hazards and redirects into stage
// enables, bubble/flush controls, saturating perf counters and a sticky hang watchdog.
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_req,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_redirect,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             bubble_id_ex,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] stall_mem_cnt,
    output logic [CNT_W-1:0] stall_haz_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             hang
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT);

    pipe_state_t     state_q, state_d;
    logic            imem_done_q, imem_done_d;
    logic            dmem_done_q, dmem_done_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic            hang_q, hang_d;

    logic      imem_ok, dmem_ok, adv, haz;
    stage_en_t en;
    logic      bubble, flush;

    always_comb begin
        imem_ok = !imem_req || imem_resp || imem_done_q;
        dmem_ok = !dmem_req || dmem_resp || dmem_done_q;
        adv     = imem_ok && dmem_ok;
        haz     = ex_is_load && (ex_rd != 5'd0) &&
                  ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

        state_d = state_q;
        case (state_q)
            RUN:      if (!adv) state_d = MEM_WAIT;
            MEM_WAIT: if (adv)  state_d = RUN;
        endcase

        // An early response is parked until the other side is ready too.
        imem_done_d = adv ? 1'b0 : (imem_done_q || imem_resp);
        dmem_done_d = adv ? 1'b0 : (dmem_done_q || dmem_resp);

        wdog_d = adv ? '0 : ((wdog_q == WD_MAX) ? wdog_q : wdog_q + 1'b1);
        hang_d = hang_q || (wdog_d == WD_MAX);

        en     = EN_ALL;
        bubble = 1'b0;
        flush  = 1'b0;
        if (rst || !adv) begin
            en = EN_NONE;
        end else if (ex_redirect) begin
            bubble = 1'b1;
            flush  = 1'b1;
        end else if (haz) begin
            en     = EN_HAZ;
            bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            imem_done_q <= 1'b0;
            dmem_done_q <= 1'b0;
            wdog_q      <= '0;
            hang_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_done_q <= imem_done_d;
            dmem_done_q <= dmem_done_d;
            wdog_q      <= wdog_d;
            hang_q      <= hang_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_mem_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (!adv),
        .count (stall_mem_cnt)
    );

    sat_counter #(.W(CNT_W)) u_stall_haz_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (adv && haz && !ex_redirect),
        .count (stall_haz_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (adv && ex_redirect),
        .count (flush_cnt)
    );

    assign pc_en        = en.pc;
    assign if_id_en     = en.if_id;
    assign id_ex_en     = en.id_ex;
    assign ex_mem_en    = en.ex_mem;
    assign mem_wb_en    = en.mem_wb;
    assign bubble_id_ex = bubble;
    assign flush_if_id  = flush;
    assign hang         = hang_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: a cycle-level reference model checked every cycle,
// plus hand-computed literal expectations at the interesting points of each scenario.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 4;
    localparam int TIMEOUT = 8;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst;
    logic             imem_req, imem_resp, dmem_req, dmem_resp;
    logic [4:0]       id_rs1, id_rs2, ex_rd;
    logic             id_use_rs1, id_use_rs2, ex_is_load, ex_redirect;
    logic             pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             bubble_id_ex, flush_if_id, hang;
    logic [CNT_W-1:0] stall_mem_cnt, stall_haz_cnt, flush_cnt;

    pipeline_ctrl #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_resp     (imem_resp),
        .dmem_req      (dmem_req),
        .dmem_resp     (dmem_resp),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .id_use_rs1    (id_use_rs1),
        .id_use_rs2    (id_use_rs2),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .ex_redirect   (ex_redirect),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .mem_wb_en     (mem_wb_en),
        .bubble_id_ex  (bubble_id_ex),
        .flush_if_id   (flush_if_id),
        .stall_mem_cnt (stall_mem_cnt),
        .stall_haz_cnt (stall_haz_cnt),
        .flush_cnt     (flush_cnt),
        .hang          (hang)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a request is satisfied once its response has been seen since the last advance.
    bit got_i, got_d, m_hang;
    int m_mem, m_haz, m_flush, m_wdog;

    function automatic bit m_adv();
        return (!imem_req || imem_resp || got_i) && (!dmem_req || dmem_resp || got_d);
    endfunction

    function automatic bit m_hazard();
        return ex_is_load && (ex_rd != 0) &&
               ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    endfunction

    function automatic int sat_inc(input int v);
        return (v >= SAT) ? SAT : v + 1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            got_i <= 1'b0; got_d <= 1'b0; m_hang <= 1'b0;
            m_mem <= 0; m_haz <= 0; m_flush <= 0; m_wdog <= 0;
        end else if (!m_adv()) begin
            got_i  <= got_i || imem_resp;
            got_d  <= got_d || dmem_resp;
            m_mem  <= sat_inc(m_mem);
            m_wdog <= m_wdog + 1;
            if (m_wdog + 1 >= TIMEOUT) m_hang <= 1'b1;
        end else begin
            got_i  <= 1'b0;
            got_d  <= 1'b0;
            m_wdog <= 0;
            if (ex_redirect)     m_flush <= sat_inc(m_flush);
            else if (m_hazard()) m_haz   <= sat_inc(m_haz);
        end
    end

    always @(negedge clk) begin
        logic [4:0] e_en;
        logic       e_bub, e_fl;
        e_en = 5'b11111; e_bub = 1'b0; e_fl = 1'b0;
        if (rst || !m_adv()) begin
            e_en = 5'b00000;
        end else if (ex_redirect) begin
            e_bub = 1'b1; e_fl = 1'b1;
        end else if (m_hazard()) begin
            e_en = 5'b00111; e_bub = 1'b1;
        end
        check("enables", {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en}, {27'd0, e_en});
        check("bubble_id_ex", {31'd0, bubble_id_ex}, {31'd0, e_bub});
        check("flush_if_id", {31'd0, flush_if_id}, {31'd0, e_fl});
        check("stall_mem_cnt", {28'd0, stall_mem_cnt}, m_mem);
        check("stall_haz_cnt", {28'd0, stall_haz_cnt}, m_haz);
        check("flush_cnt", {28'd0, flush_cnt}, m_flush);
        check("hang", {31'd0, hang}, {31'd0, m_hang});
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_req = 0; imem_resp = 0; dmem_req = 0; dmem_resp = 0;
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
        ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        @(negedge clk);
        check("rst_pc_en", {31'd0, pc_en}, 32'd0);
        step();
        rst = 1'b0;

        // Idle pipeline: free-running, counters untouched.
        repeat (10) step();
        @(negedge clk);
        check("t1_pc_en", {31'd0, pc_en}, 32'd1);
        check("t1_stall_mem", {28'd0, stall_mem_cnt}, 32'd0);
        step();

        // Responses in different cycles: freeze until both are in.
        imem_req = 1; dmem_req = 1;
        for (int c = 0; c < 7; c++) begin
            imem_resp = (c == 3);
            dmem_resp = (c == 6);
            @(negedge clk);
            if (c == 3) check("t2_pc_en_c3", {31'd0, pc_en}, 32'd0);
            if (c == 6) check("t2_pc_en_c6", {31'd0, pc_en}, 32'd1);
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("t2_stall_mem", {28'd0, stall_mem_cnt}, 32'd6);
        step();

        // Load-use on rs2, then the x0 exclusion.
        ex_is_load = 1; ex_rd = 5; id_use_rs2 = 1; id_rs2 = 5;
        @(negedge clk);
        check("t3_pc_en", {31'd0, pc_en}, 32'd0);
        check("t3_bubble", {31'd0, bubble_id_ex}, 32'd1);
        step();
        ex_rd = 0; id_rs2 = 0;
        @(negedge clk);
        check("t3_x0_bubble", {31'd0, bubble_id_ex}, 32'd0);
        check("t3_haz_cnt", {28'd0, stall_haz_cnt}, 32'd1);
        step();
        id_use_rs2 = 0; id_use_rs1 = 1; id_rs1 = 7; ex_rd = 7;
        @(negedge clk);
        check("t3_rs1_bubble", {31'd0, bubble_id_ex}, 32'd1);
        step();
        ex_is_load = 0;
        @(negedge clk);
        check("t3_noload_bubble", {31'd0, bubble_id_ex}, 32'd0);
        check("t3_haz_cnt2", {28'd0, stall_haz_cnt}, 32'd2);
        step();

        // Redirect beats load-use.
        ex_is_load = 1; ex_redirect = 1;
        @(negedge clk);
        check("t4_flush", {31'd0, flush_if_id}, 32'd1);
        check("t4_bubble", {31'd0, bubble_id_ex}, 32'd1);
        check("t4_pc_en", {31'd0, pc_en}, 32'd1);
        step();
        idle_inputs();
        @(negedge clk);
        check("t4_flush_cnt", {28'd0, flush_cnt}, 32'd1);
        check("t4_haz_cnt", {28'd0, stall_haz_cnt}, 32'd2);
        step();

        // Redirect held across a 4-cycle D-cache stall: one flush on the resp cycle.
        dmem_req = 1; ex_redirect = 1;
        for (int c = 0; c < 5; c++) begin
            dmem_resp = (c == 4);
            @(negedge clk);
            check("t5_flush", {31'd0, flush_if_id}, {31'd0, c == 4});
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("t5_flush_cnt", {28'd0, flush_cnt}, 32'd2);
        check("t5_stall_mem", {28'd0, stall_mem_cnt}, 32'd10);
        step();

        // Simultaneous responses must not leave a stale done flag behind.
        imem_req = 1; dmem_req = 1;
        for (int c = 0; c < 4; c++) begin
            imem_resp = (c == 1 || c == 3);
            dmem_resp = (c == 1 || c == 3);
            @(negedge clk);
            check("t7_pc_en", {31'd0, pc_en}, {31'd0, c == 1 || c == 3});
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("t7_stall_mem", {28'd0, stall_mem_cnt}, 32'd12);
        step();

        // Watchdog, counter saturation, sticky hang cleared only by reset.
        imem_req = 1;
        for (int c = 0; c < 13; c++) begin
            imem_resp = (c == 12);
            @(negedge clk);
            if (c == 7) check("t6_hang_c7", {31'd0, hang}, 32'd0);
            if (c == 8) check("t6_hang_c8", {31'd0, hang}, 32'd1);
            if (c == 12) begin
                check("t6_pc_en_resp", {31'd0, pc_en}, 32'd1);
                check("t6_stall_sat", {28'd0, stall_mem_cnt}, 32'd15);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("t6_hang_sticky", {31'd0, hang}, 32'd1);
        step();
        rst = 1;
        @(negedge clk);
        check("t6_rst_pc_en", {31'd0, pc_en}, 32'd0);
        step();
        rst = 0;
        @(negedge clk);
        check("t6_hang_clr", {31'd0, hang}, 32'd0);
        check("t6_stall_clr", {28'd0, stall_mem_cnt}, 32'd0);
        check("t6_flush_clr", {28'd0, flush_cnt}, 32'd0);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
